// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID->EX pipeline register of the 16-bit MIPS core:
// default widths, ALUOp encodings and the per-edge update action type.
package id_ex_stage_reg_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int REG_AW_DEF  = 3;
    localparam int ALUOP_W_DEF = 2;
    localparam int CNT_W_DEF   = 16;

    // ALUOp classes decoded further by the ALU control in EX
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    // What the stage register does on the coming clock edge, highest priority first
    typedef enum logic [2:0] {
        UPD_FLUSH,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_LOAD,
        UPD_IDLE
    } upd_e;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard detector: a valid load in EX whose destination
// (rt, never r0) is a source of the valid instruction waiting in ID.
module load_use_detect #(
    parameter int REG_AW = 3
) (
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              ex_valid_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    output logic              hazard_o
);

    // Bubbles in EX carry no load, and r0 is hardwired so it can never be stale
    always_comb begin
        hazard_o = id_valid_i && ex_valid_i && ex_memread_i && (ex_rt_i != '0) &&
                   ((id_rs_i == ex_rt_i) || (id_rt_i == ex_rt_i));
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid/ready handshake, branch flush,
// load-use bubble insertion and a saturating bubble counter.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_pc_plus_two,
    input  logic [DATA_W-1:0]  in_read_data_1,
    input  logic [DATA_W-1:0]  in_read_data_2,
    input  logic [DATA_W-1:0]  in_immediate,
    input  logic [REG_AW-1:0]  in_rs,
    input  logic [REG_AW-1:0]  in_rt,
    input  logic [REG_AW-1:0]  in_rd,
    input  logic               in_alu_src,
    input  logic               in_regdest,
    input  logic               in_memread,
    input  logic               in_memwrite,
    input  logic               in_branch,
    input  logic               in_memtoreg,
    input  logic               in_regwrite,
    input  logic [ALUOP_W-1:0] in_aluop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  O_pc_plus_two,
    output logic [DATA_W-1:0]  O_read_data_1,
    output logic [DATA_W-1:0]  O_read_data_2,
    output logic [DATA_W-1:0]  O_immediate,
    output logic [REG_AW-1:0]  O_rs,
    output logic [REG_AW-1:0]  O_rt,
    output logic [REG_AW-1:0]  O_rd,
    output logic               O_alu_src,
    output logic               O_regdest,
    output logic               O_memread,
    output logic               O_memwrite,
    output logic               O_branch,
    output logic               O_memtoreg,
    output logic               O_regwrite,
    output logic [ALUOP_W-1:0] O_aluop,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int CTRL_W = 7 + ALUOP_W;
    localparam int DP_W   = 4 * DATA_W + 3 * REG_AW;

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_in;
    logic [DP_W-1:0]   dp_q, dp_d, dp_in;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              advance;
    upd_e              upd;

    // Control bits are zeroed on any bubble; datapath fields are only ever loaded
    assign ctrl_in = {in_alu_src, in_regdest, in_memread, in_memwrite,
                      in_branch, in_memtoreg, in_regwrite, in_aluop};
    assign dp_in   = {in_pc_plus_two, in_read_data_1, in_read_data_2, in_immediate,
                      in_rs, in_rt, in_rd};

    assign {O_alu_src, O_regdest, O_memread, O_memwrite,
            O_branch, O_memtoreg, O_regwrite, O_aluop} = ctrl_q;
    assign {O_pc_plus_two, O_read_data_1, O_read_data_2, O_immediate,
            O_rs, O_rt, O_rd} = dp_q;
    assign out_valid  = valid_q;
    assign bubble_cnt = cnt_q;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .id_valid_i   (in_valid),
        .id_rs_i      (in_rs),
        .id_rt_i      (in_rt),
        .ex_valid_i   (valid_q),
        .ex_memread_i (O_memread),
        .ex_rt_i      (O_rt),
        .hazard_o     (hazard_stall)
    );

    // EX slot can take something new when empty or when downstream is draining it
    always_comb begin
        advance  = !valid_q || out_ready;
        in_ready = advance && !hazard_stall && !flush;
    end

    // Pick the single action for this edge; flush beats a stall, a stall beats a bubble
    always_comb begin
        upd = UPD_IDLE;
        if (flush) begin
            upd = UPD_FLUSH;
        end else if (!advance) begin
            upd = UPD_HOLD;
        end else if (hazard_stall) begin
            upd = UPD_BUBBLE;
        end else if (in_valid) begin
            upd = UPD_LOAD;
        end
    end

    // Next-state for the register bank and the saturating bubble counter
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        dp_d    = dp_q;
        cnt_d   = cnt_q;
        case (upd)
            UPD_FLUSH, UPD_IDLE: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
            UPD_BUBBLE: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UPD_LOAD: begin
                valid_d = 1'b1;
                ctrl_d  = ctrl_in;
                dp_d    = dp_in;
            end
            default: begin
            end
        endcase
    end

    // State registers; reset discards any in-flight instruction entirely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            dp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            dp_q    <= dp_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg. A second instance with a 2-bit bubble
// counter shares the stimulus so counter saturation is reached in a few hazards.
module tb_id_ex_stage_reg;

    // Control bundle order: alu_src, regdest, memread, memwrite, branch, memtoreg, regwrite, aluop[1:0]
    localparam logic [8:0] CTRL_NONE = 9'b0_0_0_0_0_0_0_00;
    localparam logic [8:0] CTRL_LW   = 9'b1_0_1_0_0_1_1_00;
    localparam logic [8:0] CTRL_ADD  = 9'b0_1_0_0_0_0_1_10;
    localparam logic [8:0] CTRL_SW   = 9'b1_0_0_1_0_0_0_00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_pc, in_rd1, in_rd2, in_imm;
    logic [2:0]  in_rs, in_rt, in_rd;
    logic [8:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready, out_valid, hazard_stall;
    logic [15:0] o_pc, o_rd1, o_rd2, o_imm, bubble_cnt;
    logic [2:0]  o_rs, o_rt, o_rd;
    logic        o_alu_src, o_regdest, o_memread, o_memwrite, o_branch, o_memtoreg, o_regwrite;
    logic [1:0]  o_aluop;
    logic [8:0]  obsCtrl;

    logic        s_in_ready, s_out_valid, s_hazard_stall;
    logic [15:0] s_pc, s_rd1, s_rd2, s_imm;
    logic [2:0]  s_rs, s_rt, s_rd;
    logic        s_alu_src, s_regdest, s_memread, s_memwrite, s_branch, s_memtoreg, s_regwrite;
    logic [1:0]  s_aluop;
    logic [1:0]  s_bubble_cnt;

    int checkCount = 0;
    int errorCount = 0;

    assign obsCtrl = {o_alu_src, o_regdest, o_memread, o_memwrite,
                      o_branch, o_memtoreg, o_regwrite, o_aluop};

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_pc_plus_two (in_pc), .in_read_data_1 (in_rd1), .in_read_data_2 (in_rd2),
        .in_immediate (in_imm), .in_rs (in_rs), .in_rt (in_rt), .in_rd (in_rd),
        .in_alu_src (in_ctrl[8]), .in_regdest (in_ctrl[7]), .in_memread (in_ctrl[6]),
        .in_memwrite (in_ctrl[5]), .in_branch (in_ctrl[4]), .in_memtoreg (in_ctrl[3]),
        .in_regwrite (in_ctrl[2]), .in_aluop (in_ctrl[1:0]),
        .out_valid (out_valid), .out_ready (out_ready),
        .O_pc_plus_two (o_pc), .O_read_data_1 (o_rd1), .O_read_data_2 (o_rd2),
        .O_immediate (o_imm), .O_rs (o_rs), .O_rt (o_rt), .O_rd (o_rd),
        .O_alu_src (o_alu_src), .O_regdest (o_regdest), .O_memread (o_memread),
        .O_memwrite (o_memwrite), .O_branch (o_branch), .O_memtoreg (o_memtoreg),
        .O_regwrite (o_regwrite), .O_aluop (o_aluop),
        .hazard_stall (hazard_stall), .bubble_cnt (bubble_cnt)
    );

    id_ex_stage_reg #(.CNT_W (2)) dutSmall (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (s_in_ready),
        .in_pc_plus_two (in_pc), .in_read_data_1 (in_rd1), .in_read_data_2 (in_rd2),
        .in_immediate (in_imm), .in_rs (in_rs), .in_rt (in_rt), .in_rd (in_rd),
        .in_alu_src (in_ctrl[8]), .in_regdest (in_ctrl[7]), .in_memread (in_ctrl[6]),
        .in_memwrite (in_ctrl[5]), .in_branch (in_ctrl[4]), .in_memtoreg (in_ctrl[3]),
        .in_regwrite (in_ctrl[2]), .in_aluop (in_ctrl[1:0]),
        .out_valid (s_out_valid), .out_ready (out_ready),
        .O_pc_plus_two (s_pc), .O_read_data_1 (s_rd1), .O_read_data_2 (s_rd2),
        .O_immediate (s_imm), .O_rs (s_rs), .O_rt (s_rt), .O_rd (s_rd),
        .O_alu_src (s_alu_src), .O_regdest (s_regdest), .O_memread (s_memread),
        .O_memwrite (s_memwrite), .O_branch (s_branch), .O_memtoreg (s_memtoreg),
        .O_regwrite (s_regwrite), .O_aluop (s_aluop),
        .hazard_stall (s_hazard_stall), .bubble_cnt (s_bubble_cnt)
    );

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one instruction (or an empty slot) from ID
    task automatic applyStimulus(input logic v, input logic [15:0] pc, input logic [15:0] rd1,
                                 input logic [15:0] rd2, input logic [15:0] imm,
                                 input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                                 input logic [8:0] ctrl);
        in_valid = v;
        in_pc    = pc;
        in_rd1   = rd1;
        in_rd2   = rd2;
        in_imm   = imm;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_ctrl  = ctrl;
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, CTRL_NONE);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        $display("[TB] reset state");
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst ctrl", 32'(obsCtrl), 32'(CTRL_NONE));
        checkOutput("rst pc", 32'(o_pc), 32'h0);
        checkOutput("rst bubble_cnt", 32'(bubble_cnt), 32'd0);
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);

        $display("[TB] pass-through");
        applyStimulus(1'b1, 16'h0010, 16'h1234, 16'hABCD, 16'h0004, 3'd1, 3'd2, 3'd4, CTRL_ADD);
        #1;
        checkOutput("pt in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("pt out_valid", 32'(out_valid), 32'd1);
        checkOutput("pt pc", 32'(o_pc), 32'h0010);
        checkOutput("pt rd1", 32'(o_rd1), 32'h1234);
        checkOutput("pt rd2", 32'(o_rd2), 32'hABCD);
        checkOutput("pt imm", 32'(o_imm), 32'h0004);
        checkOutput("pt regs", 32'({o_rs, o_rt, o_rd}), 32'({3'd1, 3'd2, 3'd4}));
        checkOutput("pt ctrl", 32'(obsCtrl), 32'(CTRL_ADD));

        $display("[TB] load-use");
        applyStimulus(1'b1, 16'h0012, 16'h0100, 16'h0000, 16'h0008, 3'd5, 3'd3, 3'd0, CTRL_LW);
        #1;
        checkOutput("lw in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("lw ctrl", 32'(obsCtrl), 32'(CTRL_LW));
        applyStimulus(1'b1, 16'h0014, 16'h1111, 16'h2222, 16'h0000, 3'd3, 3'd6, 3'd7, CTRL_ADD);
        #1;
        checkOutput("lu hazard", 32'(hazard_stall), 32'd1);
        checkOutput("lu in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("bub out_valid", 32'(out_valid), 32'd0);
        checkOutput("bub ctrl", 32'(obsCtrl), 32'(CTRL_NONE));
        checkOutput("bub pc held", 32'(o_pc), 32'h0012);
        checkOutput("bub count", 32'(bubble_cnt), 32'd1);
        checkOutput("bub hazard gone", 32'(hazard_stall), 32'd0);
        checkOutput("bub in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("use out_valid", 32'(out_valid), 32'd1);
        checkOutput("use pc", 32'(o_pc), 32'h0014);
        checkOutput("use ctrl", 32'(obsCtrl), 32'(CTRL_ADD));
        checkOutput("use count", 32'(bubble_cnt), 32'd1);

        $display("[TB] downstream stall");
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0016, 16'hAAAA, 16'h5555, 16'h0002, 3'd1, 3'd2, 3'd3, CTRL_SW);
        #1;
        checkOutput("stall in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall pc", 32'(o_pc), 32'h0014);
            checkOutput("stall ctrl", 32'(obsCtrl), 32'(CTRL_ADD));
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("release pc", 32'(o_pc), 32'h0016);
        checkOutput("release ctrl", 32'(obsCtrl), 32'(CTRL_SW));

        $display("[TB] flush during stall");
        out_ready = 1'b0;
        flush     = 1'b1;
        applyStimulus(1'b1, 16'h0018, 16'h0F0F, 16'hF0F0, 16'h0001, 3'd2, 3'd3, 3'd4, CTRL_ADD);
        #1;
        checkOutput("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("flush out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush regwrite", 32'(o_regwrite), 32'd0);
        checkOutput("flush memwrite", 32'(o_memwrite), 32'd0);
        checkOutput("flush pc held", 32'(o_pc), 32'h0016);
        checkOutput("flush count", 32'(bubble_cnt), 32'd1);
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, CTRL_NONE);
        tick();
        checkOutput("dropped out_valid", 32'(out_valid), 32'd0);

        $display("[TB] r0 load");
        applyStimulus(1'b1, 16'h0020, 16'h0000, 16'h0000, 16'h0004, 3'd1, 3'd0, 3'd0, CTRL_LW);
        tick();
        checkOutput("r0 lw memread", 32'(o_memread), 32'd1);
        applyStimulus(1'b1, 16'h0022, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd5, CTRL_ADD);
        #1;
        checkOutput("r0 hazard", 32'(hazard_stall), 32'd0);
        checkOutput("r0 in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("r0 use pc", 32'(o_pc), 32'h0022);

        $display("[TB] counter saturation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0030 + 16'(4 * i), 16'h0, 16'h0, 16'h0, 3'd1, 3'd4, 3'd0, CTRL_LW);
            tick();
            applyStimulus(1'b1, 16'h0032 + 16'(4 * i), 16'h0, 16'h0, 16'h0, 3'd4, 3'd6, 3'd7, CTRL_ADD);
            #1;
            checkOutput("sat hazard", 32'(hazard_stall), 32'd1);
            tick();
            checkOutput("sat count", 32'(bubble_cnt), 32'(2 + i));
            checkOutput("sat small count", 32'(s_bubble_cnt), (2 + i > 3) ? 32'd3 : 32'(2 + i));
            tick();
            checkOutput("sat use valid", 32'(out_valid), 32'd1);
        end

        $display("[TB] async reset mid-transfer");
        applyStimulus(1'b1, 16'h0040, 16'h7777, 16'h8888, 16'h0002, 3'd1, 3'd2, 3'd3, CTRL_ADD);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst ctrl", 32'(obsCtrl), 32'(CTRL_NONE));
        checkOutput("arst pc", 32'(o_pc), 32'h0);
        checkOutput("arst rd1", 32'(o_rd1), 32'h0);
        checkOutput("arst count", 32'(bubble_cnt), 32'd0);
        checkOutput("arst small count", 32'(s_bubble_cnt), 32'd0);
        checkOutput("arst in_ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
